// File: rtl/noc_phase_sequencer_if.sv
// Control/status bundle between the NoC top level and noc_phase_sequencer.
// master = run controller side, slave = the sequencer itself.
interface noc_phase_sequencer_if #(
  parameter int NUM_ROUTERS = 16,
  parameter int OP_W        = 3,
  parameter int IDX_W       = 4,
  parameter int CYCLE_W     = 32
);
  logic                        start;
  logic                        abort;
  logic [CYCLE_W-1:0]          max_cycle;
  logic [NUM_ROUTERS-1:0]      rt_valid_mask;
  logic [NUM_ROUTERS-1:0]      traffic_pending;
  logic [NUM_ROUTERS-1:0]      routers_idle;
  logic [NUM_ROUTERS*OP_W-1:0] router_op_vec;
  logic [NUM_ROUTERS*OP_W-1:0] traffic_op_vec;
  logic [IDX_W-1:0]            rt_stage;
  logic [CYCLE_W-1:0]          in_cycle;
  logic                        busy;
  logic                        done;
  logic [1:0]                  exit_reason;

  modport master (
    output start, abort, max_cycle, rt_valid_mask, traffic_pending, routers_idle,
    input  router_op_vec, traffic_op_vec, rt_stage, in_cycle, busy, done, exit_reason
  );

  modport slave (
    input  start, abort, max_cycle, rt_valid_mask, traffic_pending, routers_idle,
    output router_op_vec, traffic_op_vec, rt_stage, in_cycle, busy, done, exit_reason
  );
endinterface

// File: rtl/noc_phase_sequencer.sv
// Run sequencer for N routers / N traffic sources: init, routing-table load, fill, then
// staging/phase0/phase1 cycles. Define DRAIN_EXIT_EN to also end a run once the network drains.
module noc_phase_sequencer #(
  parameter int NUM_ROUTERS = 16,
  parameter int OP_W        = 3,
  parameter int IDX_W       = 4,
  parameter int CYCLE_W     = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  noc_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD_RT, S_FILL, S_LOAD_STAGING, S_PHASE0, S_PHASE1, S_DONE
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_INIT    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD_RT = OP_W'(2);
  localparam logic [OP_W-1:0] OP_STAGING = OP_W'(3);
  localparam logic [OP_W-1:0] OP_PHASE0  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_PHASE1  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_FILL    = OP_W'(6);

  localparam logic [1:0] EXIT_MAX   = 2'd0;
  localparam logic [1:0] EXIT_DRAIN = 2'd1;
  localparam logic [1:0] EXIT_ABORT = 2'd2;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_rt_stage, w_rt_stage_next;
  logic [CYCLE_W-1:0] r_in_cycle, w_in_cycle_next;
  logic [CYCLE_W-1:0] r_max_cycle, w_max_cycle_next;
  logic [1:0]         r_exit_reason, w_exit_reason_next;
  logic               r_start_d;
  logic [CYCLE_W-1:0] w_cycle_inc;
  logic               w_start_rise;
  logic               w_busy;
  logic               w_drain;

  assign w_start_rise = bus.start & ~r_start_d;
  assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_cycle_inc  = (&r_in_cycle) ? r_in_cycle : r_in_cycle + CYCLE_W'(1);

`ifdef DRAIN_EXIT_EN
  assign w_drain = (&bus.routers_idle) && (bus.traffic_pending == '0);
`else
  logic w_unused_idle;
  assign w_unused_idle = &bus.routers_idle;
  assign w_drain       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rt_stage    <= '0;
      r_in_cycle    <= '0;
      r_max_cycle   <= '0;
      r_exit_reason <= EXIT_MAX;
      r_start_d     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rt_stage    <= w_rt_stage_next;
      r_in_cycle    <= w_in_cycle_next;
      r_max_cycle   <= w_max_cycle_next;
      r_exit_reason <= w_exit_reason_next;
      r_start_d     <= bus.start;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_rt_stage_next    = r_rt_stage;
    w_in_cycle_next    = r_in_cycle;
    w_max_cycle_next   = r_max_cycle;
    w_exit_reason_next = r_exit_reason;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_next     = S_INIT;
          w_max_cycle_next = bus.max_cycle;
          w_in_cycle_next  = '0;
          w_rt_stage_next  = '0;
        end
      end
      S_INIT: begin
        w_state_next    = S_LOAD_RT;
        w_rt_stage_next = '0;
      end
      S_LOAD_RT: begin
        if (r_rt_stage == IDX_W'(NUM_ROUTERS - 1)) begin
          w_rt_stage_next = '0;
          w_state_next    = S_FILL;
        end else begin
          w_rt_stage_next = r_rt_stage + IDX_W'(1);
        end
      end
      S_FILL: begin
        if (bus.traffic_pending == '0) w_state_next = S_LOAD_STAGING;
      end
      S_LOAD_STAGING: w_state_next = S_PHASE0;
      S_PHASE0:       w_state_next = S_PHASE1;
      S_PHASE1: begin
        w_in_cycle_next = w_cycle_inc;
        // max_cycle exit is checked first so it wins over a simultaneous drain
        if ((r_max_cycle != '0) && (w_cycle_inc == r_max_cycle)) begin
          w_state_next       = S_DONE;
          w_exit_reason_next = EXIT_MAX;
        end else if (w_drain) begin
          w_state_next       = S_DONE;
          w_exit_reason_next = EXIT_DRAIN;
        end else begin
          w_state_next = S_LOAD_STAGING;
        end
      end
      S_DONE: begin
        if (!bus.start) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // abort overrides whatever the busy state had planned, including the cycle count
    if (w_busy && bus.abort) begin
      w_state_next       = S_DONE;
      w_exit_reason_next = EXIT_ABORT;
      w_in_cycle_next    = r_in_cycle;
      w_rt_stage_next    = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROUTERS; gi++) begin : g_slot
      logic [OP_W-1:0] w_router_op;
      logic [OP_W-1:0] w_traffic_op;

      always_comb begin
        w_router_op  = OP_NOP;
        w_traffic_op = OP_NOP;
        case (r_state)
          S_INIT: begin
            w_router_op  = OP_INIT;
            w_traffic_op = OP_INIT;
          end
          S_LOAD_RT: begin
            if (bus.rt_valid_mask[gi]) w_router_op = OP_LOAD_RT;
          end
          S_FILL: begin
            if (bus.traffic_pending[gi]) w_traffic_op = OP_FILL;
          end
          S_LOAD_STAGING: w_router_op = OP_STAGING;
          S_PHASE0:       w_router_op = OP_PHASE0;
          S_PHASE1:       w_router_op = OP_PHASE1;
          default: begin
            w_router_op  = OP_NOP;
            w_traffic_op = OP_NOP;
          end
        endcase
      end

      assign bus.router_op_vec[gi*OP_W +: OP_W]  = w_router_op;
      assign bus.traffic_op_vec[gi*OP_W +: OP_W] = w_traffic_op;
    end
  endgenerate

  assign bus.rt_stage    = r_rt_stage;
  assign bus.in_cycle    = r_in_cycle;
  assign bus.busy        = w_busy;
  assign bus.done        = (r_state == S_DONE);
  assign bus.exit_reason = r_exit_reason;

endmodule

// File: doc/noc_phase_sequencer.md
Name: noc_phase_sequencer

Overview:
Synthesisable sequencer that replaces the hard-coded testbench control loop for N routers and N traffic sources. It drives the per-router and per-traffic op codes through these stages: init, routing-table load, traffic fill, then repeated staging/phase0/phase1 simulation cycles. Router count, cycle counter width and run limit are parametrised; it adds reset, start/abort handshake, a per-router routing-table mask and a fill loop that runs until no traffic is pending. It sits above the router/traffic arrays in the NoC top level.

Parameters:
NUM_ROUTERS, 16, number of routers and traffic sources driven
OP_W, 3, op-code width per router/traffic slot
IDX_W, 4, width of rt_stage; must be >= clog2(NUM_ROUTERS)
CYCLE_W, 32, width of simulation cycle counter and max_cycle

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge observed in IDLE begins a run
abort  in  1  forces DONE on the next edge from any busy state
max_cycle  in  CYCLE_W  simulation cycles to run; 0 = unlimited; sampled at start
rt_valid_mask  in  NUM_ROUTERS  bit i = router i has a routing entry for destination rt_stage
traffic_pending  in  NUM_ROUTERS  bit i = source i still has packets to fill
routers_idle  in  NUM_ROUTERS  bit i = router i empty (used only with DRAIN_EXIT_EN)
router_op_vec  out  NUM_ROUTERS*OP_W  op for router i at bits [i*OP_W +: OP_W]
traffic_op_vec  out  NUM_ROUTERS*OP_W  op for traffic source i
rt_stage  out  IDX_W  destination index being loaded
in_cycle  out  CYCLE_W  completed simulation cycles
busy  out  1  high from INIT until DONE
done  out  1  high in DONE
exit_reason  out  2  0 = max_cycle reached, 1 = drained, 2 = abort

Behaviour:
- Op encoding: NOP=0, Init=1, LoadRt=2, LoadStaging=3, Phase0=4, Phase1=5, Fill=6.
- Reset (asynchronous): state=IDLE, rt_stage=0, in_cycle=0, busy=0, done=0, exit_reason=0. Reset mid-run takes effect immediately, with no partial completion.
- op outputs are decoded combinationally from the registered state, rt_stage and the current inputs. Slots not listed for a state drive NOP.
- IDLE: all ops NOP. A start rising edge latches max_cycle and moves to INIT.
- INIT (1 cycle): every router_op = Init and every traffic_op = Init. Next state is LOAD_RT with rt_stage=0.
- LOAD_RT (NUM_ROUTERS cycles): router i op = LoadRt if rt_valid_mask[i], else NOP. rt_stage increments each cycle. After the stage NUM_ROUTERS-1 cycle, rt_stage returns to 0 and the state moves to FILL.
- FILL: traffic i op = Fill if traffic_pending[i]. The state stays in FILL while any pending bit is set. The first cycle with traffic_pending==0 drives all NOP and moves to LOAD_STAGING, so FILL lasts at least 1 cycle.
- LOAD_STAGING -> PHASE0 -> PHASE1: each lasts 1 cycle, with all routers driven with the matching op.
- On the PHASE1 edge, in_cycle increments (saturating at all-ones). The next state is then chosen as follows:
  - if max_cycle != 0 and the new in_cycle == max_cycle: DONE, exit_reason=0
  - otherwise: LOAD_STAGING
- DONE: all ops NOP, done=1, busy=0. It holds until start is low, then goes to IDLE. done clears on leaving DONE; in_cycle holds until the next INIT clears it.
- abort has priority over every transition out of a busy state: the next state is DONE with exit_reason=2. abort in IDLE or DONE is ignored.
- A start edge while busy is ignored.

Optional Feature:
DRAIN_EXIT_EN
- Defined: on the PHASE1 edge, if &routers_idle and traffic_pending==0 and the max_cycle exit does not apply, go to DONE with exit_reason=1. The max_cycle exit wins when both hold on the same edge.
- Not defined: routers_idle is unused and exit_reason never equals 1.

Test Plan:
- Reset: rst_n low during PHASE0 with in_cycle=7 -> immediately IDLE, all ops 0, in_cycle=0, busy=0, done=0.
- Routing-table load: NUM_ROUTERS=4, rt_valid_mask=4'b1011, start -> 1 cycle of all Init, then 4 LoadRt cycles with rt_stage=0,1,2,3; router 2 sees NOP in all four; routers 0,1,3 see LoadRt.
- Fill loop: traffic_pending=4'b0101 for 3 cycles, then 0 -> 3 cycles with Fill on sources 0,2 and NOP on 1,3; then 1 all-NOP FILL cycle; then LOAD_STAGING.
- max_cycle exit: max_cycle=5 -> exactly 5 LoadStaging/Phase0/Phase1 triplets, then done=1, exit_reason=0, in_cycle=5; dropping start returns to IDLE.
- Abort: max_cycle=0, abort asserted during the 3rd PHASE0 -> DONE next edge, exit_reason=2, in_cycle=2.
- DRAIN_EXIT_EN: max_cycle=100, routers_idle=4'hF and traffic_pending=0 from cycle 3 onward -> DONE after the 3rd PHASE1, exit_reason=1, in_cycle=3. With the macro undefined, the run reaches in_cycle=100 with exit_reason=0.
